// File: rtl/am_modulator.sv
// Full-carrier AM modulator: AC-couples the offset-binary baseband, forms the envelope with a
// programmable depth, multiplies by the carrier, then rounds and saturates to OW bits.
module am_modulator #(
  parameter int SH = 7,
  parameter int OW = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [7:0]           cos_s,
  input  logic signed [7:0]    cos_c,
  input  logic [7:0]           mod_idx,
  input  logic                 idx_load,
  input  logic                 clr_sat,
  output logic signed [OW-1:0] am_out,
  output logic                 am_valid,
  output logic                 sat_flag,
  output logic [15:0]          sat_cnt
);

  localparam logic signed [18:0] R_MAX = 19'((1 <<< (OW - 1)) - 1);
  localparam logic signed [18:0] R_MIN = 19'(-(1 <<< (OW - 1)));

  function automatic logic signed [18:0] round_shift(input logic signed [17:0] x);
    logic signed [18:0] t;
    t = {x[17], x} + (19'sd1 <<< (SH - 1));
    return t >>> SH;
  endfunction

  function automatic logic signed [OW-1:0] sat_clamp(input logic signed [18:0] r);
    if (r > R_MAX)      return R_MAX[OW-1:0];
    else if (r < R_MIN) return R_MIN[OW-1:0];
    else                return r[OW-1:0];
  endfunction

  logic [7:0]         r_idx_pend;
  logic [7:0]         r_idx_act;
  logic               r_c_sign_prev;
  logic signed [8:0]  r_s_ac_p0;
  logic signed [7:0]  r_c_p0;
  logic               r_vld_p0;
  logic signed [9:0]  r_env_p1;
  logic signed [7:0]  r_c_p1;
  logic               r_vld_p1;

  logic signed [17:0] w_s_ext;
  logic signed [17:0] w_idx_ext;
  logic signed [17:0] w_p;
  logic signed [17:0] w_env_ext;
  logic signed [17:0] w_c_ext;
  logic signed [17:0] w_prod;
  logic signed [18:0] w_r;
  logic               w_ovf;
  logic               w_sat_evt;

  assign w_s_ext   = {{9{r_s_ac_p0[8]}}, r_s_ac_p0};
  assign w_idx_ext = {10'd0, r_idx_act};
  assign w_p       = w_s_ext * w_idx_ext;
  assign w_env_ext = {{8{r_env_p1[9]}}, r_env_p1};
  assign w_c_ext   = {{10{r_c_p1[7]}}, r_c_p1};
  assign w_prod    = w_env_ext * w_c_ext;
  assign w_r       = round_shift(w_prod);
  assign w_ovf     = (w_r > R_MAX) || (w_r < R_MIN);
  assign w_sat_evt = en && r_vld_p1 && w_ovf;

  // Depth takes effect only on a negative-to-non-negative carrier crossing to avoid envelope steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx_pend    <= 8'd128;
      r_idx_act     <= 8'd128;
      r_c_sign_prev <= 1'b0;
    end else begin
      if (idx_load) r_idx_pend <= mod_idx;
      if (en) begin
        r_c_sign_prev <= cos_c[7];
        if (r_c_sign_prev && !cos_c[7]) r_idx_act <= r_idx_pend;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ac_p0 <= '0;
      r_c_p0    <= '0;
      r_vld_p0  <= 1'b0;
      r_env_p1  <= '0;
      r_c_p1    <= '0;
      r_vld_p1  <= 1'b0;
      am_out    <= '0;
      am_valid  <= 1'b0;
    end else if (en) begin
      // Stage p0: AC-coupling
      r_s_ac_p0 <= $signed({1'b0, cos_s}) - 9'sd128;
      r_c_p0    <= cos_c;
      r_vld_p0  <= 1'b1;
      // Stage p1: depth scaling and envelope (floor of p/256)
      r_env_p1  <= 10'sd256 + $signed(w_p[17:8]);
      r_c_p1    <= r_c_p0;
      r_vld_p1  <= r_vld_p0;
      // Stage p2: carrier multiply, round, saturate
      am_out    <= sat_clamp(w_r);
      am_valid  <= r_vld_p1;
    end else begin
      am_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      sat_cnt  <= '0;
    end else if (clr_sat) begin
      sat_flag <= w_sat_evt;
      sat_cnt  <= w_sat_evt ? 16'd1 : 16'd0;
    end else if (w_sat_evt) begin
      sat_flag <= 1'b1;
      if (sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule
